mmul_host_seq: RTL

//  Upstream host sequencer for the 256-bit modular multiplier. Accepts a command and a
//  16-bit operand word stream (valid/ready), drives the multiplier's load strobes and

---
 rtl/mmul_pkg.sv | 27 ++
 rtl/mmul_host_seq.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/mmul_pkg.sv
// mmul_pkg
//   Shared definitions for the modular-multiplier host sequencer:
//   default word width / operand length / watchdog limit, the command
//   op codes and the sequencer state encoding.
package mmul_pkg;

  localparam int DW_DEF    = 16;    // multiplier datain width
  localparam int WORDS_DEF = 16;    // 256-bit operand / DW
  localparam int TMO_DEF   = 4096;  // WAIT watchdog limit in cycles

  // Command op codes
  localparam logic [1:0] OP_LOAD_PAB = 2'b00;  // load P, A, B
  localparam logic [1:0] OP_LOAD_AB  = 2'b01;  // load A, B (reuse P)
  localparam logic [1:0] OP_LOAD_B   = 2'b10;  // load B (reuse A, P)
  localparam logic [1:0] OP_RSVD     = 2'b11;  // reserved, flags err

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_P = 3'd1,
    ST_LOAD_A = 3'd2,
    ST_LOAD_B = 3'd3,
    ST_START  = 3'd4,
    ST_WAIT   = 3'd5,
    ST_READ   = 3'd6
  } state_t;

endpackage

// File: rtl/mmul_host_seq.sv
// mmul_host_seq
//   Host-side sequencer for the 256-bit modular multiplier. Takes a command
//   (op, result select) and a DW-bit operand word stream, drives the
//   multiplier load strobes and shared datain bus, starts a run, waits for
//   m_rdy and streams the selected result register back out.
//
// Optional feature: define MMUL_SEQ_TIMEOUT_EN to add a WAIT watchdog of TMO
//   cycles; on expiry err is set, m_en drops and the sequencer returns to
//   IDLE without reading a result. Without the macro WAIT is unbounded.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   cmd_valid/cmd_ready       command handshake (ready only in IDLE)
//   cmd_op[1:0], cmd_rsel     op code, result source (0 = C, 1 = D)
//   in_valid/in_ready/in_data operand word stream, LS word first
//   out_valid/out_ready       result word handshake
//   out_data, out_last        result word (LS first), final-word marker
//   busy                      sequencer not idle
//   err                       sticky: reserved op or timeout
//   m_datain                  multiplier datain bus
//   m_loadp/m_loada/m_loadb   multiplier operand load strobes
//   m_en                      multiplier run enable (registered)
//   m_outc/m_outd             multiplier result shift strobes
//   m_cout/m_dout, m_rdy      multiplier result words and done flag
module mmul_host_seq
  import mmul_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int WORDS = WORDS_DEF
`ifdef MMUL_SEQ_TIMEOUT_EN
  ,
  parameter int TMO   = TMO_DEF
`endif
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic          cmd_rsel,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic          busy,
  output logic          err,
  output logic [DW-1:0] m_datain,
  output logic          m_loadp,
  output logic          m_loada,
  output logic          m_loadb,
  output logic          m_en,
  output logic          m_outc,
  output logic          m_outd,
  input  logic [DW-1:0] m_cout,
  input  logic [DW-1:0] m_dout,
  input  logic          m_rdy
);

  localparam int            CW        = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [CW-1:0] LAST_WORD = CW'(WORDS - 1);

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          rsel_reg, rsel_next;
  logic          err_reg, err_next;
  logic          m_en_reg;
  logic          word_hs;
  logic          cnt_last;

  assign cnt_last = (cnt_reg == LAST_WORD);
  assign err      = err_reg;
  assign m_en     = m_en_reg;

`ifdef MMUL_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TMO + 1);

  logic [TW-1:0] tmo_cnt_reg;
  logic          tmo_hit;

  // Counts cycles spent in WAIT; tmo_hit marks the TMO-th such cycle.
  assign tmo_hit = (tmo_cnt_reg == TW'(TMO - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      tmo_cnt_reg <= '0;
    else if (state_reg == ST_WAIT)
      tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
    else
      tmo_cnt_reg <= '0;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      rsel_reg  <= 1'b0;
      err_reg   <= 1'b0;
      m_en_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      rsel_reg  <= rsel_next;
      err_reg   <= err_next;
      // Enable is high for exactly the WAIT cycles: it rises on the edge
      // leaving START and falls on the edge that sees m_rdy (or timeout).
      m_en_reg  <= (state_next == ST_WAIT);
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    rsel_next  = rsel_reg;
    err_next   = err_reg;
    word_hs    = 1'b0;
    cmd_ready  = 1'b0;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_data   = '0;
    out_last   = 1'b0;
    m_datain   = '0;
    m_loadp    = 1'b0;
    m_loada    = 1'b0;
    m_loadb    = 1'b0;
    m_outc     = 1'b0;
    m_outd     = 1'b0;
    busy       = (state_reg != ST_IDLE);

    case (state_reg)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          // The op only selects the entry state, so only rsel is kept.
          rsel_next = cmd_rsel;
          err_next  = 1'b0;
          case (cmd_op)
            OP_LOAD_PAB: state_next = ST_LOAD_P;
            OP_LOAD_AB:  state_next = ST_LOAD_A;
            OP_LOAD_B:   state_next = ST_LOAD_B;
            default:     err_next   = 1'b1;
          endcase
        end
      end
      ST_LOAD_P: begin
        in_ready = 1'b1;
        m_datain = in_data;
        m_loadp  = in_valid;
        word_hs  = in_valid;
        if (in_valid && cnt_last) state_next = ST_LOAD_A;
      end
      ST_LOAD_A: begin
        in_ready = 1'b1;
        m_datain = in_data;
        m_loada  = in_valid;
        word_hs  = in_valid;
        if (in_valid && cnt_last) state_next = ST_LOAD_B;
      end
      ST_LOAD_B: begin
        in_ready = 1'b1;
        m_datain = in_data;
        m_loadb  = in_valid;
        word_hs  = in_valid;
        if (in_valid && cnt_last) state_next = ST_START;
      end
      ST_START: begin
        state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (m_rdy) begin
          state_next = ST_READ;
        end
`ifdef MMUL_SEQ_TIMEOUT_EN
        else if (tmo_hit) begin
          err_next   = 1'b1;
          state_next = ST_IDLE;
        end
`endif
      end
      ST_READ: begin
        out_valid = 1'b1;
        out_data  = rsel_reg ? m_dout : m_cout;
        out_last  = cnt_last;
        // Shift only the register being read so the other keeps its value.
        m_outc    = out_ready & ~rsel_reg;
        m_outd    = out_ready & rsel_reg;
        word_hs   = out_ready;
        if (out_ready && cnt_last) state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    // One word counter serves both the load and the read phases.
    if (word_hs) cnt_next = cnt_last ? '0 : cnt_reg + 1'b1;
  end

endmodule
